// File: rtl/arb_requester.sv
// arb_requester: per-channel job front end for a shared arbiter.
// Each channel accepts a job (burst length), raises request, counts granted
// cycles until the burst is done, then pulses job_done. Grant-vector protocol
// violations are flagged on grant_err without disturbing the channel FSMs.
// Optional feature macro: ARB_REQ_TIMEOUT_EN adds a per-channel grant-wait
// timeout (TMO_CYCLES) and the timeout output port.
//
// Handshake: a job transfers on a cycle where job_valid[i] and job_ready[i]
// are both high; job_valid may rise independently of job_ready, and
// job_len[i] is sampled only on the transfer cycle. request/grant is the
// arbiter side: request[i] stays high until the burst's last granted cycle.
module arb_requester #(
  parameter int NUM_REQ    = 4,
  parameter int LEN_W      = 4,
  parameter int TMO_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       job_valid,
  input  logic [NUM_REQ*LEN_W-1:0] job_len,
  output logic [NUM_REQ-1:0]       job_ready,
  output logic [NUM_REQ-1:0]       request,
  input  logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       job_done,
  output logic                     grant_err,
`ifdef ARB_REQ_TIMEOUT_EN
  output logic [NUM_REQ-1:0]       timeout,
`endif
  output logic [2*NUM_REQ-1:0]     fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  // A zero-cycle grant-wait limit would make the timeout meaningless.
  if (TMO_CYCLES < 1) begin : g_tmo_check
    $error("arb_requester: TMO_CYCLES must be at least 1");
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic               req_q;
    logic               done_q;
    logic [LEN_W-1:0]   len_in;
`ifdef ARB_REQ_TIMEOUT_EN
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               tmo_q;
`endif

    assign len_in = job_len[i*LEN_W +: LEN_W];

    // Channel FSM: accept job, request until granted, count burst, release.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= ST_IDLE;
        len_q     <= '0;
        cnt_q     <= '0;
        req_q     <= 1'b0;
        done_q    <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        tmo_cnt_q <= '0;
        tmo_q     <= 1'b0;
`endif
      end else begin
        done_q    <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        tmo_cnt_q <= '0;
        tmo_q     <= 1'b0;
`endif
        case (state_q)
          ST_IDLE: begin
            if (job_valid[i]) begin
              // A zero length still moves one beat.
              len_q   <= (len_in == '0) ? LEN_W'(1) : len_in;
              req_q   <= 1'b1;
              state_q <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (grant[i]) begin
              // The first grant is already the first burst beat.
              if (len_q == LEN_W'(1)) begin
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_REL;
              end else begin
                cnt_q   <= len_q - LEN_W'(1);
                state_q <= ST_XFER;
              end
            end
`ifdef ARB_REQ_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) begin
              // Give up on the arbiter: abandon the job without job_done.
              req_q   <= 1'b0;
              tmo_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
`endif
          end
          ST_XFER: begin
            // Ungranted cycles simply pause the count.
            if (grant[i]) begin
              if (cnt_q == LEN_W'(1)) begin
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_REL;
              end else begin
                cnt_q <= cnt_q - LEN_W'(1);
              end
            end
          end
          ST_REL: begin
            state_q <= ST_IDLE;
          end
          default: begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign request[i]          = req_q;
    assign job_done[i]         = done_q;
    assign job_ready[i]        = reset & (state_q == ST_IDLE);
    assign fsm_state[2*i +: 2] = state_q;
`ifdef ARB_REQ_TIMEOUT_EN
    assign timeout[i]          = tmo_q;
`endif
  end

  logic [NUM_REQ-1:0] req_d1_q;
  logic               multi_hot;
  logic               stray_grant;

  // More than one grant bit set at once.
  assign multi_hot   = |(grant & (grant - NUM_REQ'(1)));
  // Grant to a channel whose request has been low this cycle and last cycle;
  // one cycle of grant after request drops is tolerated as arbiter latency.
  assign stray_grant = |(grant & ~request & ~req_d1_q);

  // Register protocol-violation flag one cycle after the offending grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_d1_q  <= '0;
      grant_err <= 1'b0;
    end else begin
      req_d1_q  <= request;
      grant_err <= multi_hot | stray_grant;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed bench for arb_requester. Driver tasks apply
// per-cycle stimulus and check request levels; job_done/grant_err events are
// pushed (with their expected cycle) into a queue that a monitor compares.
module tb_arb_requester;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 4;
  localparam int EW      = 21;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       job_valid;
  logic [NUM_REQ*LEN_W-1:0] job_len;
  logic [NUM_REQ-1:0]       job_ready;
  logic [NUM_REQ-1:0]       request;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       job_done;
  logic                     grant_err;
  logic [2*NUM_REQ-1:0]     fsm_state;
`ifdef ARB_REQ_TIMEOUT_EN
  logic [NUM_REQ-1:0]       timeout;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];

  arb_requester #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .TMO_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .job_valid (job_valid),
    .job_len   (job_len),
    .job_ready (job_ready),
    .request   (request),
    .grant     (grant),
    .job_done  (job_done),
    .grant_err (grant_err),
`ifdef ARB_REQ_TIMEOUT_EN
    .timeout   (timeout),
`endif
    .fsm_state (fsm_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic err, input logic [3:0] done);
    logic [15:0] c16;
    c16 = c[15:0];
    exp_q.push_back({c16, err, done});
  endtask

  // Drive one cycle of inputs, then check request mid-cycle.
  task automatic drive(input logic [3:0] jv, input logic [15:0] jl,
                       input logic [3:0] gr, input logic [3:0] exp_req);
    @(posedge clk);
    #1;
    job_valid = jv;
    job_len   = jl;
    grant     = gr;
    @(negedge clk);
    check_val("request", {4'b0, request}, {4'b0, exp_req});
  endtask

  // Monitor: every job_done/grant_err event must match the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [15:0]   c16;
    if (reset === 1'b1 && (job_done != '0 || grant_err)) begin
      checks++;
      c16 = cyc[15:0];
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d actual err=%b done=%b required none",
                 cyc, grant_err, job_done);
      end else begin
        e = exp_q.pop_front();
        if (e !== {c16, grant_err, job_done}) begin
          failures++;
          $display("FAIL event cyc=%0d actual err=%b done=%b required cyc=%0d err=%b done=%b",
                   cyc, grant_err, job_done, e[20:5], e[4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int b;
    reset     = 1'b0;
    job_valid = '0;
    job_len   = '0;
    grant     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_request",   {4'b0, request},   8'h00);
    check_val("rst_job_done",  {4'b0, job_done},  8'h00);
    check_val("rst_grant_err", {7'b0, grant_err}, 8'h00);
    check_val("rst_job_ready", {4'b0, job_ready}, 8'h00);
    check_val("rst_fsm_state", fsm_state,         8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("rel_job_ready", {4'b0, job_ready}, 8'h0f);

    // Single job: ch0 len=3, grant from the 2nd request cycle.
    b = cyc + 1;
    push_ev(b + 5, 1'b0, 4'b0001);
    drive(4'b0001, 16'h0003, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // Pause: ch1 len=4, grant pattern 1,0,1,1,1.
    b = cyc + 1;
    push_ev(b + 6, 1'b0, 4'b0010);
    drive(4'b0010, 16'h0040, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // Contention: all channels len=2, rotating one-hot grant.
    b = cyc + 1;
    push_ev(b + 6, 1'b0, 4'b0001);
    push_ev(b + 7, 1'b0, 4'b0010);
    push_ev(b + 8, 1'b0, 4'b0100);
    push_ev(b + 9, 1'b0, 4'b1000);
    drive(4'b1111, 16'h2222, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b0100, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b1000, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b1111);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b1110);
    drive(4'b0000, 16'h0000, 4'b0100, 4'b1100);
    drive(4'b0000, 16'h0000, 4'b1000, 4'b1000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // Multi-hot grant to two requesting channels.
    b = cyc + 1;
    push_ev(b + 2, 1'b1, 4'b0000);
    push_ev(b + 3, 1'b0, 4'b0001);
    push_ev(b + 4, 1'b0, 4'b0010);
    drive(4'b0011, 16'h0022, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0011, 4'b0011);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0011);
    drive(4'b0000, 16'h0000, 4'b0010, 4'b0010);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // ch2 len=1: grant in the release cycle is tolerated; later stray is not.
    b = cyc + 1;
    push_ev(b + 2, 1'b0, 4'b0100);
    push_ev(b + 5, 1'b1, 4'b0000);
    drive(4'b0100, 16'h0100, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0100, 4'b0100);
    drive(4'b0000, 16'h0000, 4'b0100, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0100, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // Zero length on ch3 behaves as a one-beat burst.
    b = cyc + 1;
    push_ev(b + 2, 1'b0, 4'b1000);
    drive(4'b1000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b1000, 4'b1000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

    // Reset in the middle of a ch0 len=5 burst: no job_done afterwards.
    drive(4'b0001, 16'h0005, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0001, 4'b0001);
    @(posedge clk);
    #1;
    grant = 4'b0001;
    reset = 1'b0;
    #1;
    check_val("midrst_request",   {4'b0, request},   8'h00);
    check_val("midrst_job_ready", {4'b0, job_ready}, 8'h00);
    check_val("midrst_fsm_state", fsm_state,         8'h00);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    grant = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    check_val("postrst_job_ready", {4'b0, job_ready}, 8'h0f);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);

`ifdef ARB_REQ_TIMEOUT_EN
    // Timeout after 8 ungranted REQ cycles on ch0.
    drive(4'b0001, 16'h0002, 4'b0000, 4'b0000);
    for (int k = 0; k < 8; k++) drive(4'b0000, 16'h0000, 4'b0000, 4'b0001);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    check_val("timeout_pulse", {4'b0, timeout},   8'h01);
    check_val("timeout_ready", {4'b0, job_ready}, 8'h0f);
    drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    check_val("timeout_clear", {4'b0, timeout},   8'h00);
`endif

    repeat (3) drive(4'b0000, 16'h0000, 4'b0000, 4'b0000);
    check_val("events_pending", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
